pc_sequencer: RTL

Fetch-stage controller for the PC register: computes the next PC, drives its enable, and sequences fetch against a variable-latency instruction memory. Resolves branch/jump delay slots, pipeline stalls, exceptions/ERET, and a fetch-timeout watchdog. Sits between the hazard unit, the D-stage branch logic and the M-stage exception logic on one side, and the PC register plus the IF/ID register on the other.

---
 rtl/pc_seq_defs.sv | 13 +
 rtl/fetch_timer.sv | 36 +++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pc_seq_defs.sv
// Shared definitions for the fetch-stage PC sequencer: FSM encoding and default vectors.
package pc_seq_defs;

    typedef enum logic [1:0] {
        StBoot = 2'd0,
        StRun  = 2'd1,
        StPend = 2'd2
    } seq_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/fetch_timer.sv
// Saturating count of consecutive un-acked fetch cycles; flags the last allowed cycle.
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: next-PC mux, delay-slot redirects, exceptions/ERET, fetch watchdog.
module pc_sequencer
    import pc_seq_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        stall,
    input  logic        md_busy,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic        PC_EN,
    output logic [31:0] nextPCounter,
    output logic        flush_D,
    output logic        fetch_err
);

    seq_state_e  state_q, state_d;
    logic [31:0] pend_q, pend_d;
    logic        hold;
    logic        t_clear, t_count, t_expired;

    assign hold = stall | md_busy;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (t_clear),
        .count   (t_count),
        .expired (t_expired)
    );

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        imem_req     = 1'b0;
        PC_EN        = 1'b0;
        nextPCounter = pc_cur;
        flush_D      = 1'b0;
        fetch_err    = 1'b0;
        t_clear      = 1'b0;
        t_count      = 1'b0;

        unique case (state_q)
            StBoot: state_d = StRun;
            StRun, StPend: begin
                imem_req = 1'b1;
                if (exc_req) begin
                    PC_EN        = 1'b1;
                    nextPCounter = EXC_VEC;
                    flush_D      = 1'b1;
                    state_d      = StRun;
                    t_clear      = 1'b1;
                end else if (eret) begin
                    PC_EN        = 1'b1;
                    nextPCounter = epc;
                    flush_D      = 1'b1;
                    state_d      = StRun;
                    t_clear      = 1'b1;
                end else if (t_expired && !imem_ack) begin
                    fetch_err    = 1'b1;
                    PC_EN        = 1'b1;
                    nextPCounter = EXC_VEC;
                    flush_D      = 1'b1;
                    state_d      = StRun;
                    t_clear      = 1'b1;
                end else begin
                    if (imem_ack) begin
                        t_clear = 1'b1;
                        if (!hold) begin
                            PC_EN = 1'b1;
                            if (state_q == StPend) begin
                                nextPCounter = pend_q;
                                state_d      = StRun;
                            end else begin
                                nextPCounter = pc_cur + 32'd4;
                            end
                        end
                    end else begin
                        t_count = 1'b1;
                    end
                    // Capture only from RUN; the delay slot still fetches sequentially.
                    if ((state_q == StRun) && !hold) begin
                        if (br_taken) begin
                            pend_d  = br_target;
                            state_d = StPend;
                        end else if (jmp) begin
                            pend_d  = jmp_target;
                            state_d = StPend;
                        end
                    end
                end
            end
            default: state_d = StBoot;
        endcase

        if (!reset) begin
            imem_req     = 1'b0;
            PC_EN        = 1'b0;
            nextPCounter = RESET_PC;
            flush_D      = 1'b0;
            fetch_err    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StBoot;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

endmodule
